// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and scanner state encoding for the
// scanned BCD counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    typedef enum logic [0:0] {
        SLOT_SETTLE = 1'b0,
        SLOT_SHOW   = 1'b1
    } scan_state_t;

    // Codes 10..15 are not decimal digits; they collapse to zero.
    function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
        bcd_digit_t r;
        if (d > BCD_MAX) begin
            r = BCD_MIN;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD decade: registered digit with load/sanitise and a combinational
// carry (up) or borrow (down) output that ripples into the next decade.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  bcd_digit_t load_digit,
    input  logic       cnt_en,
    input  logic       up_dn,
    input  logic       cin,
    output bcd_digit_t digit,
    output logic       cout
);

    bcd_digit_t digit_r;
    bcd_digit_t digit_n_s;
    logic       cout_s;

    // Next digit value and carry/borrow out, given the incoming carry/borrow.
    always_comb begin
        digit_n_s = digit_r;
        cout_s    = 1'b0;
        if (cin) begin
            if (up_dn) begin
                if (digit_r >= BCD_MAX) begin
                    digit_n_s = BCD_MIN;
                    cout_s    = 1'b1;
                end else begin
                    digit_n_s = digit_r + 4'd1;
                    cout_s    = 1'b0;
                end
            end else begin
                if (digit_r == BCD_MIN) begin
                    digit_n_s = BCD_MAX;
                    cout_s    = 1'b1;
                end else if (digit_r > BCD_MAX) begin
                    // Unreachable code point: recover to a legal digit.
                    digit_n_s = BCD_MAX;
                    cout_s    = 1'b0;
                end else begin
                    digit_n_s = digit_r - 4'd1;
                    cout_s    = 1'b0;
                end
            end
        end else begin
            digit_n_s = digit_r;
            cout_s    = 1'b0;
        end
    end

    // Digit register: reset beats load beats count.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_r <= BCD_MIN;
        end else if (load) begin
            digit_r <= bcd_sanitize(load_digit);
        end else if (cnt_en) begin
            digit_r <= digit_n_s;
        end else begin
            digit_r <= digit_r;
        end
    end

    assign digit = digit_r;
    assign cout  = cout_s;

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-decade BCD up/down counter with a time-multiplexed digit scanner
// feeding a BCD-to-decimal decoder (bcd_out -> A, blank -> C).
module bcd_scan_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cnt_en,
    input  logic                       up_dn,
    input  logic                       load,
    input  logic [4*DIGITS-1:0]        load_val,
    input  logic                       lzb_en,
    output logic [4*DIGITS-1:0]        count,
    output logic                       tc,
    output logic [3:0]                 bcd_out,
    output logic                       blank,
    output logic [$clog2(DIGITS)-1:0]  digit_idx
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int PS_W  = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);

    bcd_digit_t        digit_s [DIGITS];
    logic              carry_top_s;
    logic [DIGITS-1:0] zero_above_s;

    scan_state_t       state_r;
    scan_state_t       state_n_s;
    logic [PS_W-1:0]   prescaler_r;
    logic [PS_W-1:0]   prescaler_n_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_n_s;
    logic              blank_n_s;
    logic              tc_n_s;

    logic              tc_r;
    bcd_digit_t        bcd_out_r;
    logic              blank_r;

    // Decade chain: digit 0 always sees a carry-in, so a step ripples
    // upward through every decade sitting at its limit in the same cycle.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic cin_s;
        logic cout_s;

        if (i == 0) begin : g_lsd
            assign cin_s = 1'b1;
        end else begin : g_chain
            assign cin_s = g_digit[i-1].cout_s;
        end

        bcd_digit_cell u_cell (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .load_digit (load_val[4*i +: 4]),
            .cnt_en     (cnt_en),
            .up_dn      (up_dn),
            .cin        (cin_s),
            .digit      (digit_s[i]),
            .cout       (cout_s)
        );

        assign count[4*i +: 4] = digit_s[i];
    end

    assign carry_top_s = g_digit[DIGITS-1].cout_s;

    // zero_above_s[i]: digit i and every more-significant digit are zero.
    always_comb begin : zero_scan
        logic run_v;
        run_v        = 1'b1;
        zero_above_s = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run_v           = run_v & (digit_s[i] == BCD_MIN);
            zero_above_s[i] = run_v;
        end
    end

    // Scanner next state, slot index, prescaler and the blank value that
    // goes with the slot being entered.
    always_comb begin
        state_n_s     = state_r;
        prescaler_n_s = prescaler_r + PS_W'(1);
        idx_n_s       = idx_r;
        blank_n_s     = 1'b1;

        if (prescaler_r == PS_LAST) begin
            prescaler_n_s = '0;
            if (idx_r == IDX_LAST) begin
                idx_n_s = '0;
            end else begin
                idx_n_s = idx_r + IDX_W'(1);
            end
        end else begin
            prescaler_n_s = prescaler_r + PS_W'(1);
            idx_n_s       = idx_r;
        end

        case (state_r)
            SLOT_SETTLE: begin
                state_n_s = SLOT_SHOW;
            end
            SLOT_SHOW: begin
                if (prescaler_r == PS_LAST) begin
                    state_n_s = SLOT_SETTLE;
                end else begin
                    state_n_s = SLOT_SHOW;
                end
            end
            default: begin
                state_n_s = SLOT_SETTLE;
            end
        endcase

        // The settle slot hides the stale digit still on bcd_out.
        case (state_n_s)
            SLOT_SETTLE: blank_n_s = 1'b1;
            SLOT_SHOW:   blank_n_s = lzb_en && (idx_n_s != '0) && zero_above_s[idx_n_s];
            default:     blank_n_s = 1'b1;
        endcase
    end

    // A wrap is the top decade carrying/borrowing out on a real step.
    always_comb begin
        tc_n_s = 1'b0;
        if (cnt_en && !load) begin
            tc_n_s = carry_top_s;
        end else begin
            tc_n_s = 1'b0;
        end
    end

    // Scanner state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= SLOT_SETTLE;
            prescaler_r <= '0;
            idx_r       <= '0;
        end else begin
            state_r     <= state_n_s;
            prescaler_r <= prescaler_n_s;
            idx_r       <= idx_n_s;
        end
    end

    // Registered display and terminal-count outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tc_r      <= 1'b0;
            bcd_out_r <= BCD_MIN;
            blank_r   <= 1'b1;
        end else begin
            tc_r      <= tc_n_s;
            bcd_out_r <= digit_s[idx_r];
            blank_r   <= blank_n_s;
        end
    end

    assign tc        = tc_r;
    assign bcd_out   = bcd_out_r;
    assign blank     = blank_r;
    assign digit_idx = idx_r;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed plus randomized bench for bcd_scan_counter (DIGITS=2, SCAN_DIV=4)
// against an arithmetic reference model of count, tc and the scanned display.
module tb_bcd_scan_counter;

    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 4;
    localparam int MODULUS  = 100;

    logic                       clk;
    logic                       rst;
    logic                       cnt_en;
    logic                       up_dn;
    logic                       load;
    logic [4*DIGITS-1:0]        load_val;
    logic                       lzb_en;
    logic [4*DIGITS-1:0]        count;
    logic                       tc;
    logic [3:0]                 bcd_out;
    logic                       blank;
    logic [$clog2(DIGITS)-1:0]  digit_idx;

    int   n_cmp;
    int   n_err;

    // Reference model state: count as a plain integer, cycles since reset.
    int   m_val;
    int   m_cyc;
    int   m_bcd;
    logic m_tc;
    logic m_blank;

    bcd_scan_counter #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_en    (cnt_en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .lzb_en    (lzb_en),
        .count     (count),
        .tc        (tc),
        .bcd_out   (bcd_out),
        .blank     (blank),
        .digit_idx (digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pow10(input int e);
        int r;
        r = 1;
        for (int k = 0; k < e; k++) r = r * 10;
        return r;
    endfunction

    function automatic int dig(input int v, input int i);
        return (v / pow10(i)) % 10;
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'(dig(v, i));
        return r;
    endfunction

    function automatic int from_load(input logic [4*DIGITS-1:0] lv);
        int v;
        int d;
        v = 0;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 0;
            v = v + d * pow10(i);
        end
        return v;
    endfunction

    function automatic int idx_of(input int c);
        return (c / SCAN_DIV) % DIGITS;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs sampled at the edge,
    // then compare every output shortly after the edge.
    task automatic step();
        int ncyc;
        int nidx;
        int pos;
        @(posedge clk);
        if (rst) begin
            m_val   = 0;
            m_tc    = 1'b0;
            m_bcd   = 0;
            m_blank = 1'b1;
            m_cyc   = 0;
        end else begin
            m_bcd   = dig(m_val, idx_of(m_cyc));
            ncyc    = (m_cyc + 1) % (SCAN_DIV * DIGITS);
            nidx    = idx_of(ncyc);
            pos     = ncyc % SCAN_DIV;
            m_blank = (pos == 0) || (lzb_en && (nidx != 0) && ((m_val / pow10(nidx)) == 0));
            if (load) begin
                m_val = from_load(load_val);
                m_tc  = 1'b0;
            end else if (cnt_en && up_dn) begin
                m_tc  = (m_val == MODULUS - 1);
                m_val = (m_val + 1) % MODULUS;
            end else if (cnt_en) begin
                m_tc  = (m_val == 0);
                m_val = (m_val + MODULUS - 1) % MODULUS;
            end else begin
                m_tc  = 1'b0;
            end
            m_cyc = ncyc;
        end
        #1;
        chk("model_count", 32'(count), 32'(to_bcd(m_val)));
        chk("model_tc", 32'(tc), 32'(m_tc));
        chk("model_bcd_out", 32'(bcd_out), 32'(m_bcd));
        chk("model_blank", 32'(blank), 32'(m_blank));
        chk("model_digit_idx", 32'(digit_idx), 32'(idx_of(m_cyc)));
    endtask

    initial begin
        int guard;
        n_cmp    = 0;
        n_err    = 0;
        m_val    = 0;
        m_cyc    = 0;
        m_bcd    = 0;
        m_tc     = 1'b0;
        m_blank  = 1'b1;
        rst      = 1'b1;
        cnt_en   = 1'b0;
        up_dn    = 1'b1;
        load     = 1'b0;
        load_val = '0;
        lzb_en   = 1'b0;

        // Reset held two cycles.
        step();
        step();
        chk("rst_count", 32'(count), 32'h00);
        chk("rst_tc", 32'(tc), 32'h0);
        chk("rst_blank", 32'(blank), 32'h1);
        chk("rst_idx", 32'(digit_idx), 32'h0);
        chk("rst_bcd", 32'(bcd_out), 32'h0);
        rst = 1'b0;
        repeat (4) step();
        chk("idx_after_4", 32'(digit_idx), 32'h1);

        // Up wrap.
        load = 1'b1; load_val = 8'h98;
        step();
        load = 1'b0; cnt_en = 1'b1; up_dn = 1'b1;
        step();
        chk("up_99", 32'(count), 32'h99);
        chk("up_99_tc", 32'(tc), 32'h0);
        step();
        chk("up_wrap", 32'(count), 32'h00);
        chk("up_wrap_tc", 32'(tc), 32'h1);
        cnt_en = 1'b0;
        step();
        chk("up_tc_drop", 32'(tc), 32'h0);

        // Borrow and down wrap.
        load = 1'b1; load_val = 8'h10;
        step();
        load = 1'b0; cnt_en = 1'b1; up_dn = 1'b0;
        step();
        chk("borrow", 32'(count), 32'h09);
        chk("borrow_tc", 32'(tc), 32'h0);
        cnt_en = 1'b0; load = 1'b1; load_val = 8'h00;
        step();
        load = 1'b0; cnt_en = 1'b1;
        step();
        chk("down_wrap", 32'(count), 32'h99);
        chk("down_wrap_tc", 32'(tc), 32'h1);
        cnt_en = 1'b0;
        step();
        chk("down_hold", 32'(count), 32'h99);
        chk("down_tc_drop", 32'(tc), 32'h0);

        // Load beats count; bad digit sanitised.
        load = 1'b1; cnt_en = 1'b1; up_dn = 1'b1; load_val = 8'hA7;
        step();
        chk("load_prio", 32'(count), 32'h07);
        chk("load_prio_tc", 32'(tc), 32'h0);
        cnt_en = 1'b0; load_val = 8'h05;
        step();
        load = 1'b0; lzb_en = 1'b1;

        // Leading-zero blanking enabled.
        for (int k = 0; k < 16; k++) begin
            step();
            if ((m_cyc % SCAN_DIV) == 0) begin
                chk("settle_blank", 32'(blank), 32'h1);
            end else if (idx_of(m_cyc) == 0) begin
                chk("show0_bcd", 32'(bcd_out), 32'h5);
                chk("show0_blank", 32'(blank), 32'h0);
            end else begin
                chk("show1_blanked", 32'(blank), 32'h1);
            end
        end

        // Blanking disabled: the leading zero is shown.
        lzb_en = 1'b0;
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            if ((m_cyc % SCAN_DIV) != 0 && idx_of(m_cyc) == 1) begin
                chk("show1_bcd", 32'(bcd_out), 32'h0);
                chk("show1_unblanked", 32'(blank), 32'h0);
            end
        end

        // Reset in the middle of a scan slot and a count step.
        load = 1'b1; load_val = 8'h42;
        step();
        load  = 1'b0;
        guard = 0;
        while (digit_idx != 1'b1 && guard < 8) begin
            step();
            guard++;
        end
        chk("mid_idx_reached", 32'(digit_idx), 32'h1);
        cnt_en = 1'b1; up_dn = 1'b1; rst = 1'b1;
        step();
        chk("mid_rst_count", 32'(count), 32'h00);
        chk("mid_rst_tc", 32'(tc), 32'h0);
        chk("mid_rst_blank", 32'(blank), 32'h1);
        chk("mid_rst_idx", 32'(digit_idx), 32'h0);
        chk("mid_rst_bcd", 32'(bcd_out), 32'h0);
        rst = 1'b0; cnt_en = 1'b0;

        // Randomized traffic with wrap-prone preset values.
        for (int k = 0; k < 400; k++) begin
            rst    = ($urandom_range(0, 59) == 0);
            load   = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       load_val = 8'h99;
                1:       load_val = 8'h00;
                default: load_val = 8'($urandom);
            endcase
            cnt_en = ($urandom_range(0, 3) != 0);
            up_dn  = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) == 0) lzb_en = ~lzb_en;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
